// File: rtl/hbm_port_tap_if.sv
// -----------------------------------------------------------------------------
// hbm_port_tap_if
//
// Bundle of AXI3 handshake signals observed on one HBM pseudo-channel port.
// Every signal here is driven by the real bus (traffic generator master and
// HBM port slave). The tap never drives any of them.
//
// Modports:
//   master : drives every signal (the traffic side, or a testbench)
//   slave  : sees every signal as an input (the passive tap)
//
// Signals:
//   awvalid/awready/awaddr/awlen   write address channel
//   wvalid/wready/wlast            write data channel
//   bvalid/bready/bresp            write response channel
//   arvalid/arready/araddr/arlen   read address channel
//   rvalid/rready/rlast/rresp      read data channel
// -----------------------------------------------------------------------------
interface hbm_port_tap_if #(
    parameter int ADDR_W = 33
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;

    logic              wvalid;
    logic              wready;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;

    logic              rvalid;
    logic              rready;
    logic              rlast;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awready, awaddr, awlen,
        output wvalid, wready, wlast,
        output bvalid, bready, bresp,
        output arvalid, arready, araddr, arlen,
        output rvalid, rready, rlast, rresp
    );

    // The tap is passive: even the ready signals are only observed.
    modport slave (
        input awvalid, awready, awaddr, awlen,
        input wvalid, wready, wlast,
        input bvalid, bready, bresp,
        input arvalid, arready, araddr, arlen,
        input rvalid, rready, rlast, rresp
    );
endinterface

// File: rtl/hbm_port_tap.sv
// -----------------------------------------------------------------------------
// hbm_port_tap
//
// Passive traffic tap for one HBM pseudo-channel AXI3 port. Counts accepted
// beats and responses inside a start/stop measurement window, tracks
// outstanding write/read bursts, and keeps the last accepted addresses and
// burst length visible at all times.
//
// Ports:
//   clk, reset          port clock, asynchronous active-high reset
//   start_i/stop_i/clear_i  single-cycle window control pulses
//   axi                 observed AXI3 handshakes (slave modport, inputs only)
//   wnext_o, bokay_o    one-cycle pulses per counted W beat / OKAY B response
//   iswrite_o, isread_o outstanding write / read bursts nonzero
//   awaddr_q_o, araddr_q_o  last accepted AW / AR address
//   len_o               last accepted burst length (AW wins over AR)
//   count_*_o           saturating W-beat, R-OKAY, B-OKAY and error counters
//   state_o             window state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
//   overflow_o          sticky: counter or tracker saturated on an update
//   timeout_o           sticky: DRAIN ended by timer instead of empty trackers
// -----------------------------------------------------------------------------
module hbm_port_tap #(
    parameter int ADDR_W        = 33,
    parameter int CNT_W         = 36,
    parameter int OUTS_W        = 8,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              clear_i,
    hbm_port_tap_if.slave     axi,
    output logic              wnext_o,
    output logic              bokay_o,
    output logic              iswrite_o,
    output logic              isread_o,
    output logic [ADDR_W-1:0] awaddr_q_o,
    output logic [ADDR_W-1:0] araddr_q_o,
    output logic [3:0]        len_o,
    output logic [CNT_W-1:0]  count_wnext_o,
    output logic [CNT_W-1:0]  count_rokay_o,
    output logic [CNT_W-1:0]  count_bokay_o,
    output logic [CNT_W-1:0]  count_err_o,
    output logic [3:0]        state_o,
    output logic              overflow_o,
    output logic              timeout_o
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        RUN   = 4'd1,
        DRAIN = 4'd2,
        DONE  = 4'd3
    } state_e;

    localparam int                TMR_W    = $clog2(DRAIN_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [OUTS_W-1:0] OUTS_MAX = '1;

    // Saturating add of 0..2; MSB of the result flags an attempted overshoot.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] cur,
                                               input logic [1:0]       inc);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, cur} + {{CNT_W{1'b0}}, inc};
        if (sum > {2'b00, CNT_MAX}) return {1'b1, CNT_MAX};
        return {1'b0, sum[CNT_W-1:0]};
    endfunction

    // Outstanding tracker; simultaneous inc and dec cancel. MSB flags a
    // decrement at zero or an increment at full scale.
    function automatic logic [OUTS_W:0] trk_step(input logic [OUTS_W-1:0] cur,
                                                 input logic              inc,
                                                 input logic              dec);
        if (inc && !dec) begin
            if (cur == OUTS_MAX) return {1'b1, cur};
            return {1'b0, cur + OUTS_W'(1)};
        end
        if (dec && !inc) begin
            if (cur == '0) return {1'b1, cur};
            return {1'b0, cur - OUTS_W'(1)};
        end
        return {1'b0, cur};
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_w_q, cnt_w_d;
    logic [CNT_W-1:0]  cnt_r_q, cnt_r_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0]  cnt_e_q, cnt_e_d;
    logic [OUTS_W-1:0] wr_out_q, wr_out_d;
    logic [OUTS_W-1:0] rd_out_q, rd_out_d;
    logic [TMR_W-1:0]  drain_q, drain_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [3:0]        len_q, len_d;
    logic              wnext_q, wnext_d;
    logic              bokay_q, bokay_d;
    logic              iswrite_q, iswrite_d;
    logic              isread_q, isread_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;

    // Handshake decode
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic r_ok, r_err, b_ok, b_err;

    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid  & axi.wready;
    assign b_hs  = axi.bvalid  & axi.bready;
    assign ar_hs = axi.arvalid & axi.arready;
    assign r_hs  = axi.rvalid  & axi.rready;

    assign r_ok  = r_hs && (axi.rresp == 2'b00);
    assign r_err = r_hs && (axi.rresp != 2'b00);
    assign b_ok  = b_hs && (axi.bresp == 2'b00);
    assign b_err = b_hs && (axi.bresp != 2'b00);

    // W beats are counted individually, so wlast carries no extra information.
    logic unused_ok;
    assign unused_ok = axi.wlast;

    logic [CNT_W:0]  add_w, add_r, add_b, add_e;
    logic [OUTS_W:0] trk_w, trk_r;

    assign add_w = sat_add(cnt_w_q, {1'b0, w_hs});
    assign add_r = sat_add(cnt_r_q, {1'b0, r_ok});
    assign add_b = sat_add(cnt_b_q, {1'b0, b_ok});
    assign add_e = sat_add(cnt_e_q, 2'(r_err) + 2'(b_err));
    assign trk_w = trk_step(wr_out_q, aw_hs, b_hs);
    assign trk_r = trk_step(rd_out_q, ar_hs, r_hs & axi.rlast);

    logic count_en;
    assign count_en = (state_q == RUN) || (state_q == DRAIN);

    // NOTE: every signal written here gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_w_d    = cnt_w_q;
        cnt_r_d    = cnt_r_q;
        cnt_b_d    = cnt_b_q;
        cnt_e_d    = cnt_e_q;
        wr_out_d   = wr_out_q;
        rd_out_d   = rd_out_q;
        drain_d    = drain_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        len_d      = len_q;
        wnext_d    = 1'b0;
        bokay_d    = 1'b0;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;

        // Capture runs in every state so the last transaction stays visible.
        if (aw_hs) begin
            awaddr_d = axi.awaddr;
            len_d    = axi.awlen;
        end else if (ar_hs) begin
            len_d = axi.arlen;
        end
        if (ar_hs) araddr_d = axi.araddr;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = RUN;
                    cnt_w_d    = '0;
                    cnt_r_d    = '0;
                    cnt_b_d    = '0;
                    cnt_e_d    = '0;
                    wr_out_d   = '0;
                    rd_out_d   = '0;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                // Empty trackers take priority over the timer on the same cycle.
                if (wr_out_q == '0 && rd_out_q == '0) begin
                    state_d = DONE;
                end else if (drain_q == TMR_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else if (drain_q != '1) begin
                    drain_d = drain_q + TMR_W'(1);
                end
            end
            DONE: begin
                if (clear_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // IDLE and DONE never count, so this cannot collide with the
        // zeroing done on start.
        if (count_en) begin
            cnt_w_d  = add_w[CNT_W-1:0];
            cnt_r_d  = add_r[CNT_W-1:0];
            cnt_b_d  = add_b[CNT_W-1:0];
            cnt_e_d  = add_e[CNT_W-1:0];
            wr_out_d = trk_w[OUTS_W-1:0];
            rd_out_d = trk_r[OUTS_W-1:0];
            wnext_d  = w_hs;
            bokay_d  = b_ok;
            if (add_w[CNT_W] || add_r[CNT_W] || add_b[CNT_W] || add_e[CNT_W] ||
                trk_w[OUTS_W] || trk_r[OUTS_W]) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Activity flags are registered from the next tracker value so they
    // line up with the tracker itself.
    assign iswrite_d = (wr_out_d != '0);
    assign isread_d  = (rd_out_d != '0);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_w_q    <= '0;
            cnt_r_q    <= '0;
            cnt_b_q    <= '0;
            cnt_e_q    <= '0;
            wr_out_q   <= '0;
            rd_out_q   <= '0;
            drain_q    <= '0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            len_q      <= '0;
            wnext_q    <= 1'b0;
            bokay_q    <= 1'b0;
            iswrite_q  <= 1'b0;
            isread_q   <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_w_q    <= cnt_w_d;
            cnt_r_q    <= cnt_r_d;
            cnt_b_q    <= cnt_b_d;
            cnt_e_q    <= cnt_e_d;
            wr_out_q   <= wr_out_d;
            rd_out_q   <= rd_out_d;
            drain_q    <= drain_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            len_q      <= len_d;
            wnext_q    <= wnext_d;
            bokay_q    <= bokay_d;
            iswrite_q  <= iswrite_d;
            isread_q   <= isread_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign state_o       = state_q;
    assign count_wnext_o = cnt_w_q;
    assign count_rokay_o = cnt_r_q;
    assign count_bokay_o = cnt_b_q;
    assign count_err_o   = cnt_e_q;
    assign awaddr_q_o    = awaddr_q;
    assign araddr_q_o    = araddr_q;
    assign len_o         = len_q;
    assign wnext_o       = wnext_q;
    assign bokay_o       = bokay_q;
    assign iswrite_o     = iswrite_q;
    assign isread_o      = isread_q;
    assign overflow_o    = overflow_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_hbm_port_tap.sv
// -----------------------------------------------------------------------------
// tb_hbm_port_tap
//
// Drives one tap bus into two instances: a full-size tap (default widths and
// timeout) and a small tap (4-bit counters, 2-bit trackers, 16-cycle drain
// timeout) so saturation is reachable. A behavioural model per instance is
// stepped every clock and compared against all outputs; directed tables and
// sequences add hand-computed expectations on top.
// -----------------------------------------------------------------------------
module tb_hbm_port_tap;

    localparam int AW = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start, stop, clear;

    always #5 clk = ~clk;

    hbm_port_tap_if #(.ADDR_W(AW)) bus ();

    logic          b_wnext, b_bokay, b_iswrite, b_isread, b_ovf, b_tmo;
    logic [AW-1:0] b_awaddr, b_araddr;
    logic [3:0]    b_len, b_state;
    logic [35:0]   b_cw, b_cr, b_cb, b_ce;

    logic          s_wnext, s_bokay, s_iswrite, s_isread, s_ovf, s_tmo;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [3:0]    s_len, s_state;
    logic [3:0]    s_cw, s_cr, s_cb, s_ce;

    hbm_port_tap dut (
        .clk(clk), .reset(rst), .start_i(start), .stop_i(stop), .clear_i(clear),
        .axi(bus),
        .wnext_o(b_wnext), .bokay_o(b_bokay), .iswrite_o(b_iswrite), .isread_o(b_isread),
        .awaddr_q_o(b_awaddr), .araddr_q_o(b_araddr), .len_o(b_len),
        .count_wnext_o(b_cw), .count_rokay_o(b_cr), .count_bokay_o(b_cb), .count_err_o(b_ce),
        .state_o(b_state), .overflow_o(b_ovf), .timeout_o(b_tmo)
    );

    hbm_port_tap #(.ADDR_W(AW), .CNT_W(4), .OUTS_W(2), .DRAIN_TIMEOUT(16)) dut_s (
        .clk(clk), .reset(rst), .start_i(start), .stop_i(stop), .clear_i(clear),
        .axi(bus),
        .wnext_o(s_wnext), .bokay_o(s_bokay), .iswrite_o(s_iswrite), .isread_o(s_isread),
        .awaddr_q_o(s_awaddr), .araddr_q_o(s_araddr), .len_o(s_len),
        .count_wnext_o(s_cw), .count_rokay_o(s_cr), .count_bokay_o(s_cb), .count_err_o(s_ce),
        .state_o(s_state), .overflow_o(s_ovf), .timeout_o(s_tmo)
    );

    typedef struct packed {
        bit start, stop, clear;
        bit awv, awr; logic [AW-1:0] awaddr; logic [3:0] awlen;
        bit wv, wr, wl;
        bit bv, br; logic [1:0] bresp;
        bit arv, arr; logic [AW-1:0] araddr; logic [3:0] arlen;
        bit rv, rr, rl; logic [1:0] rresp;
    } stim_t;

    // Model state: window state as a plain number, counts as integers.
    typedef struct packed {
        int st;
        longint cw, cr, cb, ce;
        int wo, ro, tmr;
        logic [AW-1:0] awa, ara;
        logic [3:0] len;
        bit wn, bo, ovf, tmo;
    } mdl_t;

    typedef struct {
        stim_t  s;
        int     st;
        longint cw, cb;
        bit     iw, wn, bo;
    } row_t;

    localparam longint CMAX_B = (64'd1 << 36) - 1;
    localparam longint CMAX_S = 15;

    int    n_vec = 0;
    int    n_err = 0;
    stim_t cur;
    mdl_t  mb, ms;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit over(input longint x, input int k, input longint cmax);
        return (k > 0) && (x + k > cmax);
    endfunction

    function automatic longint addsat(input longint x, input int k, input longint cmax);
        return (x + k > cmax) ? cmax : x + k;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input stim_t s, input longint cmax,
                                      input int omax, input int tlim);
        mdl_t n;
        bit aw, w, b, ar, r, act;
        int kr, kb, ke, t;
        n  = m;
        aw = s.awv && s.awr;
        w  = s.wv && s.wr;
        b  = s.bv && s.br;
        ar = s.arv && s.arr;
        r  = s.rv && s.rr;
        act = (m.st == 1) || (m.st == 2);
        n.wn = 0;
        n.bo = 0;
        if (aw) begin n.awa = s.awaddr; n.len = s.awlen; end
        else if (ar) n.len = s.arlen;
        if (ar) n.ara = s.araddr;
        case (m.st)
            0: if (s.start) begin
                   n.st = 1; n.cw = 0; n.cr = 0; n.cb = 0; n.ce = 0;
                   n.wo = 0; n.ro = 0; n.ovf = 0; n.tmo = 0;
               end
            1: if (s.stop) begin n.st = 2; n.tmr = 0; end
            2: if (m.wo == 0 && m.ro == 0) n.st = 3;
               else if (m.tmr == tlim - 1) begin n.st = 3; n.tmo = 1; end
               else n.tmr = m.tmr + 1;
            3: if (s.clear) n.st = 0;
            default: n.st = 0;
        endcase
        if (act) begin
            kr = (r && s.rresp == 0) ? 1 : 0;
            kb = (b && s.bresp == 0) ? 1 : 0;
            ke = ((r && s.rresp != 0) ? 1 : 0) + ((b && s.bresp != 0) ? 1 : 0);
            if (over(m.cw, int'(w), cmax) || over(m.cr, kr, cmax) ||
                over(m.cb, kb, cmax) || over(m.ce, ke, cmax)) n.ovf = 1;
            n.cw = addsat(m.cw, int'(w), cmax);
            n.cr = addsat(m.cr, kr, cmax);
            n.cb = addsat(m.cb, kb, cmax);
            n.ce = addsat(m.ce, ke, cmax);
            n.wn = w;
            n.bo = (kb == 1);
            t = m.wo + int'(aw) - int'(b);
            if (t < 0 || t > omax) n.ovf = 1; else n.wo = t;
            t = m.ro + int'(ar) - int'(r && s.rl);
            if (t < 0 || t > omax) n.ovf = 1; else n.ro = t;
        end
        return n;
    endfunction

    task automatic cmp_dut(input string p, input mdl_t m, input logic [3:0] st,
                           input logic [63:0] cw, cr, cb, ce, input logic wn, bo, iw, ir,
                           input logic [AW-1:0] awa, ara, input logic [3:0] len,
                           input logic ovf, tmo);
        check({p, ".state"},   64'(st),  64'(m.st));
        check({p, ".cnt_w"},   cw,       m.cw);
        check({p, ".cnt_r"},   cr,       m.cr);
        check({p, ".cnt_b"},   cb,       m.cb);
        check({p, ".cnt_e"},   ce,       m.ce);
        check({p, ".wnext"},   64'(wn),  64'(m.wn));
        check({p, ".bokay"},   64'(bo),  64'(m.bo));
        check({p, ".iswrite"}, 64'(iw),  64'(m.wo != 0));
        check({p, ".isread"},  64'(ir),  64'(m.ro != 0));
        check({p, ".awaddr"},  64'(awa), 64'(m.awa));
        check({p, ".araddr"},  64'(ara), 64'(m.ara));
        check({p, ".len"},     64'(len), 64'(m.len));
        check({p, ".overflow"},64'(ovf), 64'(m.ovf));
        check({p, ".timeout"}, 64'(tmo), 64'(m.tmo));
    endtask

    task automatic cmp_models();
        cmp_dut("big", mb, b_state, 64'(b_cw), 64'(b_cr), 64'(b_cb), 64'(b_ce),
                b_wnext, b_bokay, b_iswrite, b_isread, b_awaddr, b_araddr, b_len, b_ovf, b_tmo);
        cmp_dut("small", ms, s_state, 64'(s_cw), 64'(s_cr), 64'(s_cb), 64'(s_ce),
                s_wnext, s_bokay, s_iswrite, s_isread, s_awaddr, s_araddr, s_len, s_ovf, s_tmo);
    endtask

    task automatic drive(input stim_t s);
        cur = s;
        start = s.start; stop = s.stop; clear = s.clear;
        bus.awvalid = s.awv; bus.awready = s.awr; bus.awaddr = s.awaddr; bus.awlen = s.awlen;
        bus.wvalid  = s.wv;  bus.wready  = s.wr;  bus.wlast  = s.wl;
        bus.bvalid  = s.bv;  bus.bready  = s.br;  bus.bresp  = s.bresp;
        bus.arvalid = s.arv; bus.arready = s.arr; bus.araddr = s.araddr; bus.arlen = s.arlen;
        bus.rvalid  = s.rv;  bus.rready  = s.rr;  bus.rlast  = s.rl;  bus.rresp  = s.rresp;
    endtask

    // One clock: models advance on the edge the DUTs sample, outputs are
    // compared 1 time unit later; the next drive happens from there.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            mb = mdl_step(mb, cur, CMAX_B, 255, 1024);
            ms = mdl_step(ms, cur, CMAX_S, 3, 16);
        end
        #1;
        cmp_models();
    endtask

    task automatic go(input stim_t s);
        drive(s);
        step();
    endtask

    stim_t s_idle, s_start, s_stop, s_clear, s_aw, s_w, s_wstall, s_wl, s_b, s_ar, s_r, s_rl;
    row_t  tbl[11];

    initial begin
        s_idle  = '0;
        s_start = '0; s_start.start = 1;
        s_stop  = '0; s_stop.stop   = 1;
        s_clear = '0; s_clear.clear = 1;
        s_aw    = '0; s_aw.awv = 1; s_aw.awr = 1; s_aw.awaddr = 33'h1_0000_0040; s_aw.awlen = 4'd3;
        s_w     = '0; s_w.wv = 1; s_w.wr = 1;
        s_wstall = '0; s_wstall.wv = 1;
        s_wl    = s_w; s_wl.wl = 1;
        s_b     = '0; s_b.bv = 1; s_b.br = 1;
        s_ar    = '0; s_ar.arv = 1; s_ar.arr = 1; s_ar.araddr = 33'h0_1234_5600; s_ar.arlen = 4'd7;
        s_r     = '0; s_r.rv = 1; s_r.rr = 1;
        s_rl    = s_r; s_rl.rl = 1;

        // Basic write window: {stimulus, state, count_wnext, count_bokay, iswrite, wnext, bokay}
        tbl[0]  = '{s_start,  1, 0, 0, 0, 0, 0};
        tbl[1]  = '{s_aw,     1, 0, 0, 1, 0, 0};
        tbl[2]  = '{s_wstall, 1, 0, 0, 1, 0, 0};
        tbl[3]  = '{s_w,      1, 1, 0, 1, 1, 0};
        tbl[4]  = '{s_w,      1, 2, 0, 1, 1, 0};
        tbl[5]  = '{s_w,      1, 3, 0, 1, 1, 0};
        tbl[6]  = '{s_wl,     1, 4, 0, 1, 1, 0};
        tbl[7]  = '{s_b,      1, 4, 1, 0, 0, 1};
        tbl[8]  = '{s_stop,   2, 4, 1, 0, 0, 0};
        tbl[9]  = '{s_idle,   3, 4, 1, 0, 0, 0};
        tbl[10] = '{s_clear,  0, 4, 1, 0, 0, 0};

        mb = '0;
        ms = '0;
        drive(s_idle);
        repeat (2) @(posedge clk);
        #1;
        cmp_models();
        check("reset.state", 64'(b_state), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            go(tbl[i].s);
            check($sformatf("tbl%0d.state", i), 64'(b_state), 64'(tbl[i].st));
            check($sformatf("tbl%0d.cnt_w", i), 64'(b_cw), tbl[i].cw);
            check($sformatf("tbl%0d.cnt_b", i), 64'(b_cb), tbl[i].cb);
            check($sformatf("tbl%0d.iswrite", i), 64'(b_iswrite), 64'(tbl[i].iw));
            check($sformatf("tbl%0d.wnext", i), 64'(b_wnext), 64'(tbl[i].wn));
            check($sformatf("tbl%0d.bokay", i), 64'(b_bokay), 64'(tbl[i].bo));
        end
        check("basic.awaddr", 64'(b_awaddr), 64'h1_0000_0040);
        check("basic.len", 64'(b_len), 64'd3);

        // Read drain: DRAIN holds until the final R beat retires the burst.
        go(s_start);
        go(s_ar);
        check("rd.isread", 64'(b_isread), 64'd1);
        go(s_r);
        go(s_r);
        go(s_stop);
        check("rd.drain", 64'(b_state), 64'd2);
        for (int i = 0; i < 5; i++) begin
            go(s_r);
            check($sformatf("rd.hold%0d", i), 64'(b_state), 64'd2);
        end
        go(s_rl);
        check("rd.last_state", 64'(b_state), 64'd2);
        check("rd.isread0", 64'(b_isread), 64'd0);
        go(s_idle);
        check("rd.done", 64'(b_state), 64'd3);
        check("rd.count_rokay", 64'(b_cr), 64'd8);
        check("rd.araddr", 64'(b_araddr), 64'h0_1234_5600);
        check("rd.len", 64'(b_len), 64'd7);
        go(s_clear);

        // Error responses on B and R in the same cycle; AW beats AR for len.
        go(s_start);
        begin
            stim_t s;
            s = s_aw; s.awlen = 4'd1;
            s.arv = 1; s.arr = 1; s.araddr = 33'h1_ABCD_0000; s.arlen = 4'd2;
            go(s);
            check("err.len_aw_wins", 64'(b_len), 64'd1);
            s = '0;
            s.bv = 1; s.br = 1; s.bresp = 2'b10;
            s.rv = 1; s.rr = 1; s.rl = 1; s.rresp = 2'b11;
            go(s);
        end
        check("err.count_err", 64'(b_ce), 64'd2);
        check("err.count_bokay", 64'(b_cb), 64'd0);
        check("err.bokay", 64'(b_bokay), 64'd0);
        check("err.count_rokay", 64'(b_cr), 64'd0);
        go(s_stop);
        go(s_idle);
        check("err.done", 64'(b_state), 64'd3);
        go(s_clear);

        // Drain timeout with a write burst that never completes.
        go(s_start);
        go(s_aw);
        go(s_stop);
        begin
            int n;
            n = 0;
            while (b_state != 4'd3 && n < 1100) begin
                go(s_idle);
                n++;
            end
            check("tmo.cycles", 64'(n), 64'd1024);
        end
        check("tmo.timeout", 64'(b_tmo), 64'd1);
        check("tmo.iswrite", 64'(b_iswrite), 64'd1);
        go(s_w);
        check("tmo.no_count_done", 64'(b_cw), 64'd0);
        check("tmo.no_pulse_done", 64'(b_wnext), 64'd0);
        go(s_clear);

        // Saturation on the 4-bit instance.
        go(s_start);
        repeat (20) go(s_w);
        check("sat.small_cnt", 64'(s_cw), 64'd15);
        check("sat.small_ovf", 64'(s_ovf), 64'd1);
        check("sat.big_cnt", 64'(b_cw), 64'd20);
        check("sat.big_ovf", 64'(b_ovf), 64'd0);
        go(s_stop);
        go(s_idle);
        go(s_clear);

        // Asynchronous reset in the middle of a window.
        go(s_start);
        go(s_aw);
        repeat (3) go(s_w);
        check("rst.pre_cnt", 64'(b_cw), 64'd3);
        rst = 1'b1;
        mb = '0;
        ms = '0;
        #1;
        check("rst.async_state", 64'(b_state), 64'd0);
        check("rst.async_cnt", 64'(b_cw), 64'd0);
        check("rst.async_awaddr", 64'(b_awaddr), 64'd0);
        check("rst.async_iswrite", 64'(b_iswrite), 64'd0);
        cmp_models();
        @(posedge clk);
        #1;
        rst = 1'b0;
        go(s_w);
        check("rst.no_count", 64'(b_cw), 64'd0);
        check("rst.no_pulse", 64'(b_wnext), 64'd0);
        check("rst.idle", 64'(b_state), 64'd0);

        // Random traffic against the models.
        for (int i = 0; i < 3000; i++) begin
            stim_t s;
            s = '0;
            s.start  = ($urandom_range(0, 7) == 0);
            s.stop   = ($urandom_range(0, 15) == 0);
            s.clear  = ($urandom_range(0, 7) == 0);
            s.awv    = $urandom_range(0, 1) == 1; s.awr = $urandom_range(0, 1) == 1;
            s.awaddr = {1'($urandom_range(0, 1)), 32'($urandom)};
            s.awlen  = 4'($urandom);
            s.wv     = $urandom_range(0, 1) == 1; s.wr = $urandom_range(0, 1) == 1;
            s.wl     = $urandom_range(0, 3) == 0;
            s.bv     = $urandom_range(0, 1) == 1; s.br = $urandom_range(0, 1) == 1;
            s.bresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            s.arv    = $urandom_range(0, 1) == 1; s.arr = $urandom_range(0, 1) == 1;
            s.araddr = {1'($urandom_range(0, 1)), 32'($urandom)};
            s.arlen  = 4'($urandom);
            s.rv     = $urandom_range(0, 1) == 1; s.rr = $urandom_range(0, 1) == 1;
            s.rl     = $urandom_range(0, 2) == 0;
            s.rresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            go(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
